// File: rtl/feature_out_accum_buf.sv
// Accumulates MS-lane float partial sums into GN x DEPTH entries seeded from per-group bias,
// then streams the finished map group-major over valid/ready (1 beat/cycle) with optional ReLU.
module feature_out_accum_buf #(
    parameter int EW    = 5,
    parameter int MW    = 10,
    parameter int FW    = 16,
    parameter int MS    = 32,
    parameter int GN    = 16,
    parameter int DEPTH = 196,
    parameter int GW    = 4,
    parameter int AW    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [GW:0]      cfg_grp_num_i,
    input  logic             bias_wr_i,
    input  logic [GW-1:0]    bias_grp_i,
    input  logic [MS*FW-1:0] bias_data_i,
    input  logic             accum_en_i,
    input  logic [GW-1:0]    accum_grp_i,
    input  logic [AW-1:0]    accum_addr_i,
    input  logic [MS*FW-1:0] accum_data_i,
    input  logic             drain_i,
    input  logic             relu_en_i,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [MS*FW-1:0] rd_data_o,
    output logic [GW-1:0]    rd_grp_o,
    output logic [AW-1:0]    rd_addr_o,
    output logic             rd_last_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int DW = MS*FW;
    localparam int NE = GN*DEPTH;
    localparam int IW = $clog2(NE);
    localparam int XW = MW + 4;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
    state_t state, state_nxt;

    // Round-to-nearest-even adder; subnormals flush to zero, overflow saturates to infinity.
    function automatic logic [FW-1:0] float_add2(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic [FW-1:0]   x, y, r;
        logic [EW-1:0]   ex, ey;
        logic [XW-1:0]   xa, xb;
        logic [2*XW-1:0] sh;
        logic [XW:0]     s;
        logic [MW:0]     m;
        logic            rnd, found;
        int              d, e;
        if (a[FW-2:0] >= b[FW-2:0]) begin x = a; y = b; end
        else begin x = b; y = a; end
        ex = x[FW-2:MW];
        ey = y[FW-2:MW];
        r  = '0;
        if (ex == '1)      r = x;
        else if (ex == '0) r = '0;
        else if (ey == '0) r = x;
        else begin
            d  = int'(ex) - int'(ey);
            xa = {1'b1, x[MW-1:0], 3'b000};
            if (d >= XW) xb = XW'(1);
            else begin
                sh = {1'b1, y[MW-1:0], 3'b000, XW'(0)} >> d;
                xb = sh[2*XW-1:XW] | XW'(|sh[XW-1:0]);
            end
            if (x[FW-1] == y[FW-1]) s = {1'b0, xa} + {1'b0, xb};
            else                    s = {1'b0, xa} - {1'b0, xb};
            e = int'(ex);
            if (s != '0) begin
                if (s[XW]) begin
                    s = {1'b0, s[XW:2], s[1] | s[0]};
                    e = e + 1;
                end else begin
                    found = 1'b0;
                    for (int i = 0; i < XW; i++) begin
                        if (!found && !s[XW-1]) begin s = s << 1; e = e - 1; end
                        else found = 1'b1;
                    end
                end
                m   = s[XW-1:3];
                rnd = s[2] & (s[1] | s[0] | s[3]);
                if (rnd) begin
                    if (m == '1) begin m = {1'b1, MW'(0)}; e = e + 1; end
                    else m = m + (MW+1)'(1);
                end
                if (e <= 0)                 r = '0;
                else if (e >= (1<<EW) - 1)  r = {x[FW-1], {EW{1'b1}}, MW'(0)};
                else                        r = {x[FW-1], EW'(e), m[MW-1:0]};
            end
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] swap_lanes(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        for (int i = 0; i < MS; i++) r[i*FW +: FW] = d[(MS-1-i)*FW +: FW];
        return r;
    endfunction

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        for (int i = 0; i < MS; i++) r[i*FW +: FW] = d[i*FW+FW-1] ? FW'(0) : d[i*FW +: FW];
        return r;
    endfunction

    logic [DW-1:0] mem  [NE];
    logic [DW-1:0] bias [GN];
    logic [NE-1:0] touched;
    logic [GW:0]   grp_num;
    logic          relu_q;

    logic          restart, wr_ok, load, fin, nxt_last, relu_sel;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [DW-1:0] acc_base, acc_in, acc_sum, nxt_src, nxt_dat;
    logic [GW-1:0] nxt_grp;
    logic [AW-1:0] nxt_addr;

    // drain_i wins over start_i when both arrive in ACCUM
    assign restart = start_i && (state == IDLE || (state == ACCUM && !drain_i));

    always_comb begin
        wr_ok    = (state == ACCUM) && accum_en_i && (int'(accum_grp_i) < GN) && (int'(accum_addr_i) < DEPTH);
        wr_idx   = IW'(int'(accum_grp_i) * DEPTH + int'(accum_addr_i));
        acc_in   = swap_lanes(accum_data_i);
        acc_base = touched[wr_idx] ? mem[wr_idx] : bias[accum_grp_i];
        acc_sum  = '0;
        for (int i = 0; i < MS; i++) acc_sum[i*FW +: FW] = float_add2(acc_base[i*FW +: FW], acc_in[i*FW +: FW]);
    end

    always_comb begin
        nxt_grp  = '0;
        nxt_addr = '0;
        load     = 1'b0;
        fin      = 1'b0;
        if (state == ACCUM && drain_i) load = 1'b1;
        else if (state == DRAIN && rd_valid_o && rd_ready_i) begin
            if (rd_last_o) fin = 1'b1;
            else begin
                load = 1'b1;
                if (int'(rd_addr_o) == DEPTH - 1) nxt_grp = rd_grp_o + GW'(1);
                else begin
                    nxt_grp  = rd_grp_o;
                    nxt_addr = rd_addr_o + AW'(1);
                end
            end
        end
        nxt_last = (int'(nxt_grp) == int'(grp_num) - 1) && (int'(nxt_addr) == DEPTH - 1);
        rd_idx   = IW'(int'(nxt_grp) * DEPTH + int'(nxt_addr));
        // forward an accumulate landing on the first beat in the same cycle as drain_i
        if (wr_ok && wr_idx == rd_idx) nxt_src = acc_sum;
        else if (touched[rd_idx])      nxt_src = mem[rd_idx];
        else                           nxt_src = bias[nxt_grp];
        relu_sel = (state == ACCUM) ? relu_en_i : relu_q;
        nxt_dat  = relu_sel ? relu(nxt_src) : nxt_src;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = ACCUM;
            ACCUM:   if (drain_i) state_nxt = DRAIN;
            DRAIN:   if (fin)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb busy_o = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem[wr_idx] <= acc_sum;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        touched <= '0;
        else if (restart) touched <= '0;
        else if (wr_ok)   touched[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < GN; i++) bias[i] <= '0;
        end else if (bias_wr_i && state != DRAIN && int'(bias_grp_i) < GN) begin
            bias[bias_grp_i] <= swap_lanes(bias_data_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            rd_grp_o   <= '0;
            rd_addr_o  <= '0;
            rd_last_o  <= 1'b0;
            done_o     <= 1'b0;
            relu_q     <= 1'b0;
            grp_num    <= '0;
        end else begin
            done_o <= fin;
            if (restart) grp_num <= cfg_grp_num_i;
            if (state == ACCUM && drain_i) relu_q <= relu_en_i;
            if (load) begin
                rd_valid_o <= 1'b1;
                rd_data_o  <= nxt_dat;
                rd_grp_o   <= nxt_grp;
                rd_addr_o  <= nxt_addr;
                rd_last_o  <= nxt_last;
            end else if (fin) begin
                rd_valid_o <= 1'b0;
                rd_last_o  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_feature_out_accum_buf.sv
// Bench for feature_out_accum_buf: hex adder table, directed corner sequences, and randomized
// tiles checked against a real-valued model of bias seeding, accumulation and drain order.
`timescale 1ns/1ps
module tb_feature_out_accum_buf;
    localparam int EW = 5, MW = 10, FW = 16, MS = 32, GN = 16, DEPTH = 196, GW = 4, AW = 8;
    localparam int DW = MS*FW;
    localparam int NE = GN*DEPTH;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [GW:0]   cfg_grp_num_i = '0;
    logic          bias_wr_i = 1'b0;
    logic [GW-1:0] bias_grp_i = '0;
    logic [DW-1:0] bias_data_i = '0;
    logic          accum_en_i = 1'b0;
    logic [GW-1:0] accum_grp_i = '0;
    logic [AW-1:0] accum_addr_i = '0;
    logic [DW-1:0] accum_data_i = '0;
    logic          drain_i = 1'b0;
    logic          relu_en_i = 1'b0;
    logic          rd_valid_o;
    logic          rd_ready_i = 1'b0;
    logic [DW-1:0] rd_data_o;
    logic [GW-1:0] rd_grp_o;
    logic [AW-1:0] rd_addr_o;
    logic          rd_last_o;
    logic          busy_o;
    logic          done_o;

    always #5 clk_i = ~clk_i;

    feature_out_accum_buf #(.EW(EW), .MW(MW), .FW(FW), .MS(MS), .GN(GN), .DEPTH(DEPTH), .GW(GW), .AW(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .cfg_grp_num_i(cfg_grp_num_i),
        .bias_wr_i(bias_wr_i), .bias_grp_i(bias_grp_i), .bias_data_i(bias_data_i),
        .accum_en_i(accum_en_i), .accum_grp_i(accum_grp_i), .accum_addr_i(accum_addr_i),
        .accum_data_i(accum_data_i), .drain_i(drain_i), .relu_en_i(relu_en_i),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
        .rd_grp_o(rd_grp_o), .rd_addr_o(rd_addr_o), .rd_last_o(rd_last_o),
        .busy_o(busy_o), .done_o(done_o));

    int checks = 0;
    int errors = 0;

    // Reference model: values held as reals, converted to half only when compared
    real           m_bias [GN][MS];
    real           m_mem  [NE][MS];
    bit            m_touch [NE];
    int            m_grp_num;
    real           lanes [MS];
    logic [DW-1:0] cap [NE];

    typedef struct {
        logic [15:0] b;
        logic [15:0] d;
        logic [15:0] r;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] r2h(input real v);
        real a;
        int  e, f;
        logic [15:0] h;
        if (v == 0.0) return 16'h0000;
        a = (v < 0.0) ? -v : v;
        e = 15;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        f = $rtoi((a - 1.0) * 1024.0);
        h = {(v < 0.0) ? 1'b1 : 1'b0, e[4:0], f[9:0]};
        return h;
    endfunction

    function automatic logic [DW-1:0] pack_lanes();
        logic [DW-1:0] r;
        for (int i = 0; i < MS; i++) r[(MS-1-i)*FW +: FW] = r2h(lanes[i]);
        return r;
    endfunction

    function automatic logic [DW-1:0] exp_beat(input int k, input bit relu);
        logic [DW-1:0] r;
        logic [15:0]   h;
        int            g;
        g = k / DEPTH;
        for (int i = 0; i < MS; i++) begin
            h = m_touch[k] ? r2h(m_mem[k][i]) : r2h(m_bias[g][i]);
            if (relu && h[15]) h = 16'h0000;
            r[i*FW +: FW] = h;
        end
        return r;
    endfunction

    task automatic zero_lanes();
        for (int i = 0; i < MS; i++) lanes[i] = 0.0;
    endtask

    task automatic rand_lanes(input int span);
        for (int i = 0; i < MS; i++) lanes[i] = real'(int'($urandom_range(0, 2*span)) - span);
    endtask

    task automatic do_start(input int n);
        start_i = 1'b1;
        cfg_grp_num_i = (GW+1)'(n);
        @(negedge clk_i);
        start_i = 1'b0;
        m_grp_num = n;
        for (int i = 0; i < NE; i++) m_touch[i] = 1'b0;
    endtask

    task automatic do_bias(input int g);
        bias_wr_i = 1'b1;
        bias_grp_i = GW'(g);
        bias_data_i = pack_lanes();
        @(negedge clk_i);
        bias_wr_i = 1'b0;
        for (int i = 0; i < MS; i++) m_bias[g][i] = lanes[i];
    endtask

    // Drives one accumulate strobe for the coming edge; caller advances the clock
    task automatic set_acc(input int g, input int a);
        int k;
        accum_en_i = 1'b1;
        accum_grp_i = GW'(g);
        accum_addr_i = AW'(a);
        accum_data_i = pack_lanes();
        if (g < GN && a < DEPTH) begin
            k = g * DEPTH + a;
            for (int i = 0; i < MS; i++)
                m_mem[k][i] = (m_touch[k] ? m_mem[k][i] : m_bias[g][i]) + lanes[i];
            m_touch[k] = 1'b1;
        end
    endtask

    task automatic do_acc(input int g, input int a);
        set_acc(g, a);
        @(negedge clk_i);
        accum_en_i = 1'b0;
    endtask

    task automatic do_drain(input bit relu, input int mode, input bit noise);
        int n, beats, cyc;
        bit stall, fin, abort;
        logic [DW-1:0] pd;
        logic [GW-1:0] pg;
        logic [AW-1:0] pa;
        logic pl;
        n = m_grp_num * DEPTH;
        for (int k = 0; k < n; k++) cap[k] = 'x;
        drain_i = 1'b1;
        relu_en_i = relu;
        @(negedge clk_i);
        drain_i = 1'b0;
        accum_en_i = 1'b0;
        relu_en_i = 1'b0;
        beats = 0; cyc = 0; stall = 0; fin = 0; abort = 0;
        pd = '0; pg = '0; pa = '0; pl = 1'b0;
        while (!fin && !abort && cyc < n * 5 + 100) begin
            case (mode)
                0:       rd_ready_i = 1'b1;
                1:       rd_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rd_ready_i = 1'($urandom_range(0, 1));
            endcase
            if (noise) begin
                bias_wr_i = 1'b1;
                bias_grp_i = GW'($urandom_range(0, GN-1));
                bias_data_i = {16{$urandom}};
                accum_en_i = 1'($urandom_range(0, 1));
                accum_grp_i = '0;
                accum_addr_i = AW'($urandom_range(0, DEPTH-1));
                accum_data_i = {16{32'h3c003c00}};
                start_i = 1'($urandom_range(0, 1));
            end
            if (stall)
                check($sformatf("hold beat %0d", beats), {rd_valid_o, rd_data_o, rd_grp_o, rd_addr_o, rd_last_o},
                      {1'b1, pd, pg, pa, pl});
            if (rd_valid_o !== 1'b1) begin
                check($sformatf("valid at beat %0d", beats), DW'(rd_valid_o), DW'(1));
                abort = 1;
            end else if (rd_ready_i) begin
                check($sformatf("beat %0d tag", beats), DW'({rd_grp_o, rd_addr_o, rd_last_o, done_o}),
                      DW'({GW'(beats / DEPTH), AW'(beats % DEPTH), beats == n - 1, 1'b0}));
                cap[beats] = rd_data_o;
                beats++;
                stall = 0;
                if (rd_last_o || beats == n) fin = 1;
            end else begin
                stall = 1;
                pd = rd_data_o; pg = rd_grp_o; pa = rd_addr_o; pl = rd_last_o;
            end
            @(negedge clk_i);
            cyc++;
        end
        bias_wr_i = 1'b0; accum_en_i = 1'b0; start_i = 1'b0; rd_ready_i = 1'b0;
        check("drain beat count", DW'(beats), DW'(n));
        if (fin) begin
            check("valid after last", DW'(rd_valid_o), DW'(0));
            check("done pulse", DW'(done_o), DW'(1));
            check("idle after drain", DW'(busy_o), DW'(0));
            @(negedge clk_i);
            check("done single cycle", DW'(done_o), DW'(0));
        end
    endtask

    task automatic cmp_map(input bit relu, input string tag);
        for (int k = 0; k < m_grp_num * DEPTH; k++)
            check($sformatf("%s data %0d/%0d", tag, k / DEPTH, k % DEPTH), cap[k], exp_beat(k, relu));
    endtask

    initial begin
        tbl[0] = '{16'h3C00, 16'h4000, 16'h4200};
        tbl[1] = '{16'h4000, 16'h4000, 16'h4400};
        tbl[2] = '{16'hC000, 16'h4000, 16'h0000};
        tbl[3] = '{16'h3C00, 16'hBC00, 16'h0000};
        tbl[4] = '{16'h4500, 16'hC200, 16'h4000};
        tbl[5] = '{16'h3800, 16'h3800, 16'h3C00};
        tbl[6] = '{16'h7BFF, 16'h7BFF, 16'h7C00};
        tbl[7] = '{16'h3C00, 16'h1000, 16'h3C00};
        tbl[8] = '{16'h3C01, 16'h1000, 16'h3C02};
        tbl[9] = '{16'h0000, 16'hC200, 16'hC200};
        for (int g = 0; g < GN; g++) for (int i = 0; i < MS; i++) m_bias[g][i] = 0.0;

        repeat (2) @(negedge clk_i);
        check("reset rd_valid", DW'(rd_valid_o), DW'(0));
        check("reset rd_data", rd_data_o, '0);
        check("reset rd_grp", DW'(rd_grp_o), DW'(0));
        check("reset rd_addr", DW'(rd_addr_o), DW'(0));
        check("reset rd_last", DW'(rd_last_o), DW'(0));
        check("reset busy", DW'(busy_o), DW'(0));
        check("reset done", DW'(done_o), DW'(0));
        rst_i = 1'b0;
        @(negedge clk_i);

        // Adder table: group i biased with tbl[i].b, entry 5 accumulated once with tbl[i].d
        do_start(10);
        check("busy after start", DW'(busy_o), DW'(1));
        for (int i = 0; i < 10; i++) begin
            bias_wr_i = 1'b1;
            bias_grp_i = GW'(i);
            bias_data_i = '0;
            bias_data_i[DW-1 -: 16] = tbl[i].b;
            @(negedge clk_i);
            bias_wr_i = 1'b0;
            accum_en_i = 1'b1;
            accum_grp_i = GW'(i);
            accum_addr_i = AW'(5);
            accum_data_i = '0;
            accum_data_i[DW-1 -: 16] = tbl[i].d;
            @(negedge clk_i);
            accum_en_i = 1'b0;
        end
        do_drain(1'b0, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("table %0d sum", i), DW'(cap[i*DEPTH+5][15:0]), DW'(tbl[i].r));
            check($sformatf("table %0d other lanes", i), DW'(cap[i*DEPTH+5][DW-1:16]), DW'(0));
            check($sformatf("table %0d untouched", i), DW'(cap[i*DEPTH+4][15:0]), DW'(tbl[i].b));
        end

        // Chained accumulate, dropped out-of-range write, accumulate on the drain cycle, backpressure
        do_start(3);
        zero_lanes();
        for (int g = 0; g < 3; g++) do_bias(g);
        lanes[7] = 1.0;
        for (int i = 0; i < 4; i++) begin set_acc(2, 0); @(negedge clk_i); end
        for (int i = 0; i < 40; i++) begin
            rand_lanes(3);
            set_acc($urandom_range(0, 2), $urandom_range(1, DEPTH-1));
            @(negedge clk_i);
        end
        rand_lanes(3);
        set_acc(0, DEPTH);
        @(negedge clk_i);
        zero_lanes();
        lanes[0] = 2.0;
        set_acc(0, 0);
        do_drain(1'b0, 1, 1'b1);
        cmp_map(1'b0, "chain");
        check("chained g2 a0 lane7", DW'(cap[2*DEPTH][7*FW +: FW]), DW'(16'h4400));
        check("drain-cycle accum g0 a0", DW'(cap[0][15:0]), DW'(16'h4000));

        // ReLU on and off for the same entry
        for (int r = 1; r >= 0; r--) begin
            do_start(1);
            zero_lanes();
            lanes[0] = -2.0;
            lanes[1] = 2.0;
            do_acc(0, 7);
            do_drain(r[0], 0, 1'b0);
            cmp_map(r[0], r[0] ? "relu" : "norelu");
            check($sformatf("relu=%0d lane0", r), DW'(cap[7][15:0]), DW'(r[0] ? 16'h0000 : 16'hC000));
            check($sformatf("relu=%0d lane1", r), DW'(cap[7][31:16]), DW'(16'h4000));
        end

        // Randomized tiles
        for (int t = 0; t < 3; t++) begin
            do_start($urandom_range(1, 4));
            for (int g = 0; g < 4; g++) begin rand_lanes(4); do_bias(g); end
            for (int i = 0; i < 150; i++) begin
                rand_lanes(3);
                set_acc($urandom_range(0, 3), ($urandom_range(0, 15) == 0) ? $urandom_range(DEPTH, 255) : $urandom_range(0, DEPTH-1));
                if ($urandom_range(0, 3) == 0) begin @(negedge clk_i); accum_en_i = 1'b0; end
                @(negedge clk_i);
            end
            accum_en_i = 1'b0;
            begin
                bit rl;
                rl = 1'($urandom_range(0, 1));
                do_drain(rl, 2, 1'b1);
                cmp_map(rl, $sformatf("rand%0d", t));
            end
        end

        // Reset on the 10th drain beat, then restart shows bias only
        do_start(2);
        rand_lanes(4);
        do_bias(0);
        for (int i = 0; i < 5; i++) begin rand_lanes(3); do_acc(0, i); end
        drain_i = 1'b1;
        @(negedge clk_i);
        drain_i = 1'b0;
        rd_ready_i = 1'b1;
        repeat (9) @(negedge clk_i);
        check("tenth beat addr", DW'(rd_addr_o), DW'(9));
        rst_i = 1'b1;
        #1;
        check("mid-drain reset valid", DW'(rd_valid_o), DW'(0));
        check("mid-drain reset data", rd_data_o, '0);
        check("mid-drain reset tag", DW'({rd_grp_o, rd_addr_o, rd_last_o}), DW'(0));
        check("mid-drain reset busy", DW'(busy_o), DW'(0));
        check("mid-drain reset done", DW'(done_o), DW'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        rd_ready_i = 1'b0;
        for (int g = 0; g < GN; g++) for (int i = 0; i < MS; i++) m_bias[g][i] = 0.0;
        @(negedge clk_i);
        do_start(2);
        rand_lanes(4);
        do_bias(1);
        do_drain(1'b0, 0, 1'b0);
        cmp_map(1'b0, "post-reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
